// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer. It handles load-use stalls,
// flushes on control transfers, run/drain sequencing and performance counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rt_id,
  input  logic        mem_read_ex,
  input  logic [4:0]  rt_ex,
  input  logic        branch_mem,
  input  logic        zero_mem,
  input  logic        jump_mem,
  input  logic        clr_cnt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        bubble_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int unsigned CYC_W   = 32;
  localparam int unsigned EVT_W   = 16;
  localparam int unsigned DRAIN_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [DRAIN_W-1:0]   r_drain_cnt;
  logic [DRAIN_W-1:0]   w_drain_next;
  logic [CYC_W-1:0]     r_cycle_cnt;
  logic [EVT_W-1:0]     r_stall_cnt;
  logic [EVT_W-1:0]     r_flush_cnt;
  logic                 w_hazard;
  logic                 w_redirect;
  logic                 w_stall_inc;
  logic                 w_flush_inc;

  // Load-use hazard against the IF/ID sources, and taken control transfer in MEM
  always_comb begin
    w_hazard   = mem_read_ex && (rt_ex != 5'd0) &&
                 ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    w_redirect = (branch_mem && zero_mem) || jump_mem;
  end

  // Next-state, drain counter and zero-latency stage control
  always_comb begin
    w_next_state = r_state;
    w_drain_next = r_drain_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next_state = S_RUN;
      end
      S_RUN: begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        if (w_redirect) begin
          // Redirect wins over a simultaneous load-use stall
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          w_flush_inc  = 1'b1;
          w_next_state = S_FLUSH;
        end else begin
          if (w_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            bubble_ex   = 1'b1;
            w_stall_inc = 1'b1;
          end
          if (!enable) begin
            w_next_state = S_DRAIN;
            w_drain_next = DRAIN_W'(3);
          end
        end
      end
      S_FLUSH: begin
        // Discard the word the synchronous IMEM fetched from the stale PC
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        flush_if_id = 1'b1;
        if (enable) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_DRAIN;
          w_drain_next = DRAIN_W'(3);
        end
      end
      S_DRAIN: begin
        bubble_ex    = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        w_drain_next = (r_drain_cnt == '0) ? '0 : r_drain_cnt - DRAIN_W'(1);
        if (r_drain_cnt <= DRAIN_W'(1)) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and drain counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_next;
    end
  end

  // Performance counters: cycle wraps, stall/flush saturate, clear has priority
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state != S_IDLE) r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
      if (w_stall_inc && (r_stall_cnt != {EVT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + EVT_W'(1);
      if (w_flush_inc && (r_flush_cnt != {EVT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + EVT_W'(1);
    end
  end

  assign state     = r_state;
  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        uses_rt_id;
  logic        mem_read_ex;
  logic [4:0]  rt_ex;
  logic        branch_mem;
  logic        zero_mem;
  logic        jump_mem;
  logic        clr_cnt;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        bubble_ex;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .uses_rt_id   (uses_rt_id),
    .mem_read_ex  (mem_read_ex),
    .rt_ex        (rt_ex),
    .branch_mem   (branch_mem),
    .zero_mem     (zero_mem),
    .jump_mem     (jump_mem),
    .clr_cnt      (clr_cnt),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .bubble_ex    (bubble_ex),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .state        (state),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs settle 1 time unit after
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ens();
    return 32'({pc_en, if_id_en, id_ex_en, ex_mem_en});
  endfunction

  function automatic logic [31:0] fls();
    return 32'({bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem});
  endfunction

  task automatic clear_hazard_inputs();
    rs_id = 5'd0; rt_id = 5'd0; uses_rt_id = 1'b0;
    mem_read_ex = 1'b0; rt_ex = 5'd0;
    branch_mem = 1'b0; zero_mem = 1'b0; jump_mem = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b0; clr_cnt = 1'b0;
    clear_hazard_inputs();
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ens", ens(), 32'h0);
    chk("reset_flush", fls(), 32'h0);
    chk("reset_cycle", cycle_cnt, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Stays IDLE without enable
    tick(); tick();
    chk("idle_hold_state", 32'(state), 32'd0);
    chk("idle_hold_cycle", cycle_cnt, 32'd0);

    // Startup
    enable = 1'b1;
    #1;
    chk("cyc0_state", 32'(state), 32'd0);
    chk("cyc0_pc_en", 32'(pc_en), 32'd0);
    tick();
    chk("cyc1_state", 32'(state), 32'd1);
    chk("cyc1_ens", ens(), 32'hF);
    chk("cyc1_flush", fls(), 32'h0);
    repeat (5) tick();
    chk("cycle_cnt_5", cycle_cnt, 32'd5);

    // Load-use stall on rs
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8;
    #1;
    chk("lu_ens", ens(), 32'h3);
    chk("lu_flush", fls(), 32'h8);
    tick();
    clear_hazard_inputs();
    #1;
    chk("lu_state", 32'(state), 32'd1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Guards: r0 destination, rt not used; then rt used
    mem_read_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0;
    #1;
    chk("guard_r0_ens", ens(), 32'hF);
    rt_ex = 5'd9; rt_id = 5'd9; uses_rt_id = 1'b0; rs_id = 5'd3;
    #1;
    chk("guard_rt_unused_ens", ens(), 32'hF);
    chk("guard_rt_unused_bub", fls(), 32'h0);
    uses_rt_id = 1'b1;
    #1;
    chk("rt_used_ens", ens(), 32'h3);
    clear_hazard_inputs();
    tick();
    chk("guard_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch taken with simultaneous hazard
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8;
    branch_mem = 1'b1; zero_mem = 1'b1;
    #1;
    chk("br_ens", ens(), 32'hF);
    chk("br_flush", fls(), 32'h7);
    tick();
    clear_hazard_inputs();
    #1;
    chk("br_flush_state", 32'(state), 32'd2);
    chk("br_flush_ens", ens(), 32'hF);
    chk("br_flush_out", fls(), 32'h4);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("br_back_run", 32'(state), 32'd1);

    // Branch not taken (zero_mem low) is no redirect
    branch_mem = 1'b1;
    #1;
    chk("br_nt_flush", fls(), 32'h0);
    clear_hazard_inputs();

    // Drain with jump pulse ignored
    enable = 1'b0;
    tick();
    chk("dr1_state", 32'(state), 32'd3);
    chk("dr1_ens", ens(), 32'h3);
    chk("dr1_flush", fls(), 32'h8);
    jump_mem = 1'b1;
    #1;
    chk("dr_jump_flush", fls(), 32'h8);
    tick();
    jump_mem = 1'b0;
    chk("dr2_state", 32'(state), 32'd3);
    tick();
    chk("dr3_state", 32'(state), 32'd3);
    chk("dr3_ens", ens(), 32'h3);
    tick();
    chk("dr_idle_state", 32'(state), 32'd0);
    chk("dr_idle_ens", ens(), 32'h0);
    chk("dr_flush_cnt", 32'(flush_cnt), 32'd1);

    // Redirect with enable low: FLUSH then DRAIN
    enable = 1'b1;
    tick();
    chk("re_run", 32'(state), 32'd1);
    enable = 1'b0; jump_mem = 1'b1;
    #1;
    chk("re_dis_flush", fls(), 32'h7);
    tick();
    jump_mem = 1'b0;
    chk("re_dis_state_flush", 32'(state), 32'd2);
    chk("re_dis_flush_cnt", 32'(flush_cnt), 32'd2);
    tick();
    chk("re_dis_state_drain", 32'(state), 32'd3);
    repeat (3) tick();
    chk("re_dis_idle", 32'(state), 32'd0);

    // Clear overrides a concurrent stall increment, then saturate stall_cnt
    enable = 1'b1;
    tick();
    mem_read_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_over_stall", 32'(stall_cnt), 32'd0);
    chk("clr_over_cycle", cycle_cnt, 32'd0);
    chk("clr_over_flush", 32'(flush_cnt), 32'd0);
    repeat (65535) tick();
    chk("sat_reach", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("cycle_no_sat", cycle_cnt, 32'd65536);
    clear_hazard_inputs();

    // Clear all counters
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cycle", cycle_cnt, 32'd0);
    chk("clr_stall", 32'(stall_cnt), 32'd0);

    // Async reset in FLUSH takes effect without an edge
    jump_mem = 1'b1;
    tick();
    jump_mem = 1'b0;
    chk("pre_rst_state", 32'(state), 32'd2);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ens", ens(), 32'h0);
    chk("arst_flush", fls(), 32'h0);
    chk("arst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    chk("post_rst_run", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port enable, input, 1, run request from the testbench or host.
REQ-004 SHALL have ports rs_id and rt_id, input, 5 each, source register fields of the instruction in IF/ID.
REQ-005 SHALL have port uses_rt_id, input, 1, set when the IF/ID instruction reads rt (R-type, sw, beq).
REQ-006 SHALL have ports mem_read_ex (input, 1) and rt_ex (input, 5), ID/EXE load flag and load destination register.
REQ-007 SHALL have ports branch_mem, zero_mem and jump_mem, input, 1 each, EXE/MEM control-transfer signals.
REQ-008 SHALL have port clr_cnt, input, 1, synchronous clear of the performance counters.
REQ-009 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, output, 1 each, stage register enables.
REQ-010 SHALL have ports bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem, output, 1 each; each zeroes the control bits of its target register on the next edge.
REQ-011 SHALL have ports state (output, 2), cycle_cnt (output, 32), stall_cnt (output, 16) and flush_cnt (output, 16).

Function
REQ-012 SHALL implement the states IDLE=00, RUN=01, FLUSH=10 and DRAIN=11, exposed on the state port.
REQ-013 In IDLE: all enables SHALL be 0 and all flush/bubble outputs 0; enable=1 SHALL move the block to RUN on the next edge.
REQ-014 SHALL compute hazard = mem_read_ex & (rt_ex!=0) & (rt_ex==rs_id | (uses_rt_id & rt_ex==rt_id)).
REQ-015 SHALL compute redirect = (branch_mem & zero_mem) | jump_mem.
REQ-016 In RUN with no hazard and no redirect: all four enables SHALL be 1 and all flush/bubble outputs 0.
REQ-017 In RUN with hazard and no redirect, in the same cycle: pc_en=0, if_id_en=0, bubble_ex=1, id_ex_en=1, ex_mem_en=1. The state SHALL stay RUN. stall_cnt SHALL increment by 1.
REQ-018 In RUN with redirect, in the same cycle: all enables=1, flush_if_id=1, flush_id_ex=1, flush_ex_mem=1. The next state SHALL be FLUSH. flush_cnt SHALL increment by 1.
REQ-019 Redirect SHALL take priority over hazard; when both occur, no stall is counted.
REQ-020 FLUSH SHALL last exactly 1 cycle: all enables=1 and flush_if_id=1, discarding the synchronous-IMEM word fetched from the stale PC. The next state SHALL be RUN, or DRAIN if enable=0.
REQ-021 RUN with enable=0 and no redirect SHALL go to DRAIN and load a 2-bit drain counter with 3.
REQ-022 In DRAIN: pc_en=0, if_id_en=0, bubble_ex=1, id_ex_en=1, ex_mem_en=1.
REQ-023 In DRAIN the drain counter SHALL decrement each cycle; on reaching 0 the next state SHALL be IDLE, regardless of enable.
REQ-024 A redirect arriving in DRAIN SHALL be ignored: no flush outputs and no flush_cnt increment.
REQ-025 A redirect in RUN with enable=0 SHALL be serviced (go to FLUSH); the FLUSH-to-DRAIN rule then applies.
REQ-026 cycle_cnt SHALL increment by 1 every cycle the state is not IDLE.
REQ-027 stall_cnt and flush_cnt SHALL saturate at 0xFFFF; cycle_cnt SHALL wrap modulo 2^32.
REQ-028 clr_cnt=1 SHALL zero all three counters on the next edge, overriding any increment in that cycle.
REQ-029 All outputs other than the counters SHALL be a combinational function of state, the drain counter and the inputs, with zero latency.

Reset
REQ-030 arst_n=0 SHALL immediately force state=IDLE, drain counter=0, all counters=0, all enables=0 and all flush/bubble outputs=0, including mid-FLUSH or mid-DRAIN.
REQ-031 After release of arst_n, the block SHALL remain in IDLE until enable=1 is sampled on a rising edge.

Verification
REQ-032 Reset, then enable=1: state=IDLE in cycle 0 with pc_en=0; state=RUN from cycle 1 with all enables=1; cycle_cnt=5 after 5 RUN cycles.
REQ-033 Load-use: mem_read_ex=1, rt_ex=8, rs_id=8 for 1 cycle -> pc_en=0, if_id_en=0, bubble_ex=1 in that cycle; stall_cnt=1.
REQ-034 Load-use guard: rt_ex=0, rs_id=0 with mem_read_ex=1 -> no stall. rt_ex=9, rt_id=9, uses_rt_id=0 -> no stall.
REQ-035 Branch taken: branch_mem=1, zero_mem=1, with hazard also present -> three flush outputs=1, bubble_ex=0, state=FLUSH next cycle with flush_if_id=1, then RUN; flush_cnt=1, stall_cnt unchanged.
REQ-036 Drop enable in RUN -> DRAIN for exactly 3 cycles with pc_en=0, bubble_ex=1, then IDLE. A jump_mem=1 pulse during DRAIN -> no flush.
REQ-037 Preload stall_cnt to 0xFFFF, force one more stall -> stays 0xFFFF. clr_cnt=1 -> all counters 0. arst_n=0 during FLUSH -> state=IDLE with no edge.
